// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NUM_REQ
// clients. The winning command is registered onto the RAM port. Read returns
// are routed back to the issuing client through a small {valid, index} pipeline.
module mem_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_data,
    input  logic [DATA_W-1:0]         mem_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // One stage per cycle between the issue edge and the edge that captures mem_out.
    localparam int DEPTH = RD_LAT + 1;
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W:0]    cand;
    logic [IDX_W-1:0]  win_idx;
    logic              win_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic [NUM_REQ-1:0] rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    logic              pipe_vld_q [DEPTH];
    logic [IDX_W-1:0]  pipe_idx_q [DEPTH];

    // Pick the first requester at or after ptr (wrapping). No grant during reset.
    always_comb begin
        gnt       = '0;
        win_idx   = '0;
        win_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!win_valid && !rst && req[cand[IDX_W-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
        if (win_valid) begin
            gnt[win_idx] = 1'b1;
        end
    end

    // Winner's command and the pointer value following this transfer.
    always_comb begin
        sel_we   = req_we[win_idx];
        sel_addr = req_addr[win_idx*ADDR_W +: ADDR_W];
        sel_data = req_data[win_idx*DATA_W +: DATA_W];
        ptr_d    = ptr_q;
        if (win_valid) begin
            ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
        end
    end

    // RAM command register and round-robin pointer; idle cycles hold addr/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            mem_we_q <= win_valid & sel_we;
            if (win_valid) begin
                mem_addr_q <= sel_addr;
                mem_data_q <= sel_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                // Stage 0 records a read issued on this edge and who issued it.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        pipe_vld_q[gi] <= 1'b0;
                        pipe_idx_q[gi] <= '0;
                    end else begin
                        pipe_vld_q[gi] <= win_valid & ~sel_we;
                        pipe_idx_q[gi] <= win_idx;
                    end
                end
            end else begin : g_tail
                // Later stages follow the read through the RAM latency.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        pipe_vld_q[gi] <= 1'b0;
                        pipe_idx_q[gi] <= '0;
                    end else begin
                        pipe_vld_q[gi] <= pipe_vld_q[gi-1];
                        pipe_idx_q[gi] <= pipe_idx_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Capture RAM output for the read at the pipeline tail; rdata holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= '0;
            if (pipe_vld_q[DEPTH-1]) begin
                rvalid_q[pipe_idx_q[DEPTH-1]] <= 1'b1;
                rdata_q                       <= mem_out;
            end
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RAM, a reference
// memory updated in grant order, and a queue of expected read returns.
module tb_mem_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam int RL = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req, req_we, gnt, rvalid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [DW-1:0]     rdata, mem_data, mem_out;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;

    typedef struct {
        int          idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] ram [64];
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)
    ) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_out(mem_out)
    );

    // Single-port RAM, read-first, one cycle read latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
        mem_out <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop/compare returns, then record this cycle's transfer.
    always @(negedge clk) begin
        exp_t          e;
        logic [AW-1:0] a;
        if (sb.size() > 0 && rvalid !== '0) begin
            e = sb.pop_front();
            check("rvalid_idx", 32'(rvalid), 32'(1 << e.idx));
            check("rdata", 32'(rdata), 32'(e.data));
            $display("return: rvalid=%b rdata=%h exp_idx=%0d exp_data=%h", rvalid, rdata, e.idx, e.data);
        end else if (sb.size() == 0) begin
            check("no_spurious_rvalid", 32'(rvalid), 32'(0));
        end
        if (rst) begin
            sb.delete();
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (req[i] && gnt[i]) begin
                    a = req_addr[i*AW +: AW];
                    if (req_we[i]) begin
                        ref_mem[a] = req_data[i*DW +: DW];
                        $display("grant: req%0d write addr=%0d data=%h", i, a, req_data[i*DW +: DW]);
                    end else begin
                        sb.push_back('{i, ref_mem[a]});
                        $display("grant: req%0d read addr=%0d", i, a);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]              = 1'b1;
        req_we[i]           = we;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_data = '0;
        for (int i = 0; i < NR; i++) set_cmd(i, 1'b1, '0, '0);

        // Reset with all clients requesting.
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_gnt", 32'(gnt), 32'(0));
            check("rst_mem_we", 32'(mem_we), 32'(0));
            check("rst_mem_addr", 32'(mem_addr), 32'(0));
            check("rst_rvalid", 32'(rvalid), 32'(0));
        end
        rst = 1'b0;
        #1;
        check("gnt_after_reset", 32'(gnt), 32'(4'b0001));
        tick();
        req = '0;
        check("first_write_we", 32'(mem_we), 32'(1));

        // Write addr 5 then read it back on the following cycle.
        set_cmd(0, 1'b1, 6'd5, 16'hA5A5);
        #1;
        check("wr_gnt", 32'(gnt), 32'(4'b0001));
        tick();
        check("wr_mem_we", 32'(mem_we), 32'(1));
        check("wr_mem_addr", 32'(mem_addr), 32'(5));
        check("wr_mem_data", 32'(mem_data), 32'(16'hA5A5));
        set_cmd(0, 1'b0, 6'd5, '0);
        #1;
        check("rd_gnt", 32'(gnt), 32'(4'b0001));
        tick();
        req = '0;
        check("rd_mem_we", 32'(mem_we), 32'(0));
        check("rd_mem_addr", 32'(mem_addr), 32'(5));
        tick();
        check("rd_not_early", 32'(rvalid), 32'(0));
        tick();
        check("rd_rvalid", 32'(rvalid), 32'(4'b0001));
        check("rd_rdata", 32'(rdata), 32'(16'hA5A5));
        tick();
        check("rvalid_one_cycle", 32'(rvalid), 32'(0));
        check("rdata_held", 32'(rdata), 32'(16'hA5A5));

        // Prefill one word per client, one client at a time; pointer ends at 0.
        for (int i = 0; i < NR; i++) begin
            req = '0;
            set_cmd(i, 1'b1, 6'(20 + i), 16'(16'h1000 + i * 16'h0111));
            #1;
            check("prefill_gnt", 32'(gnt), 32'(1 << i));
            tick();
        end
        req = '0;

        // All clients read continuously: strict rotation 0,1,2,3,...
        for (int i = 0; i < NR; i++) set_cmd(i, 1'b0, 6'(20 + i), '0);
        for (int c = 0; c < 12; c++) begin
            #1;
            check("rr_gnt", 32'(gnt), 32'(1 << (c % NR)));
            tick();
        end
        req = '0;
        repeat (3) tick();

        // Move pointer to 3, then sparse requests wrap 3 -> 0.
        set_cmd(2, 1'b0, 6'd22, '0);
        tick();
        req = '0;
        set_cmd(3, 1'b0, 6'd23, '0);
        set_cmd(0, 1'b1, 6'd20, 16'h1000);
        #1;
        check("wrap_gnt3", 32'(gnt), 32'(4'b1000));
        tick();
        req[3] = 1'b0;
        #1;
        check("wrap_gnt0", 32'(gnt), 32'(4'b0001));
        tick();
        req = '0;
        check("wrap_we", 32'(mem_we), 32'(1));
        tick();
        check("idle_mem_we", 32'(mem_we), 32'(0));
        check("idle_addr_hold", 32'(mem_addr), 32'(20));
        set_cmd(3, 1'b0, 6'd23, '0);
        set_cmd(0, 1'b0, 6'd20, '0);
        #1;
        check("idle_ptr_kept", 32'(gnt), 32'(4'b1000));
        req = '0;

        // Fill even addresses by clients 1 and 2 alternately, then random reads.
        for (int k = 0; k < 32; k++) begin
            req = '0;
            set_cmd((k % 2 == 0) ? 1 : 2, 1'b1, 6'(2 * k), 16'($urandom));
            tick();
        end
        for (int n = 0; n < 100; n++) begin
            req = '0;
            set_cmd(int'($urandom_range(0, NR - 1)), 1'b0, 6'(2 * $urandom_range(0, 31)), '0);
            tick();
        end
        req = '0;
        repeat (4) tick();

        // Reset while a read to addr 7 is in flight and a write is requesting.
        set_cmd(1, 1'b0, 6'd7, '0);
        tick();
        req = '0;
        set_cmd(1, 1'b1, 6'd9, 16'hBEEF);
        rst = 1'b1;
        #1;
        check("gnt_in_reset", 32'(gnt), 32'(0));
        tick();
        check("dropped_cmd_we", 32'(mem_we), 32'(0));
        rst = 1'b0;
        req = '0;
        tick();
        check("flushed_read", 32'(rvalid), 32'(0));
        tick();
        check("flushed_read_late", 32'(rvalid), 32'(0));
        for (int i = 0; i < NR; i++) set_cmd(i, 1'b0, 6'(20 + i), '0);
        #1;
        check("restart_gnt", 32'(gnt), 32'(4'b0001));
        req = '0;
        repeat (4) tick();
        check("sb_empty", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
